display_7s_page_sel: RTL and testbench
======================================

// Module: display_7s_page_sel
// PURPOSE
//  Parametrised, registered page selector for the 7-segment display path: picks one of N_CH
//  DW-bit display contents and drives dis_data to the display driver. The page index is held
//  in a register and moved by next/prev pulses, a direct load, or an auto-rotate dwell timer.
//  Sits between the content generators and the 7-segment driver; replaces the fixed 12-way mux.
// PARAMETERS
//  N_CH        12   number of content channels, 2..16
//  DW          80   width of one display content word
//  DWELL       4    auto-rotate dwell, in tick pulses, 1..255
//  SW          4    localparam: $clog2(N_CH), width of page index
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous reset, active-low
//  dis_content  in   N_CH*DW  flat content bus; channel k = dis_content[k*DW +: DW]
//  next         in   1        1-cycle pulse: advance page by +1
//  prev         in   1        1-cycle pulse: step page by -1
//  load         in   1        1-cycle pulse: load page from sel_in
//  sel_in       in   SW       page index for load
//  auto_en      in   1        level: enable auto-rotate
//  tick         in   1        1-cycle timebase strobe for dwell counting
//  dis_data     out  DW       registered selected content
//  sel          out  SW       current page index
//  sel_changed  out  1        1-cycle pulse, high in the cycle after sel changes
// BEHAVIOUR
//  - Reset (reset_n=0, async): sel=0, dwell_cnt=0, sel_changed=0, dis_data=0.
//  - Page update, evaluated on each clk edge, priority high->low:
//    1 load: sel<=sel_in if sel_in<N_CH; if sel_in>=N_CH, sel is held and no change flagged.
//    2 next&prev both high: no move (cancel).
//    3 next: sel<=(sel==N_CH-1)?0:sel+1.  prev: sel<=(sel==0)?N_CH-1:sel-1.
//    4 auto advance: auto_en & tick & dwell_cnt==DWELL-1 -> same as next.
//  - Dwell counter (8 bit): increments on tick while auto_en=1; cleared on auto advance,
//    on any manual action (load, next, prev, including ignored/cancelled ones) and while
//    auto_en=0. Manual action in the same cycle as a dwell expiry wins; no auto step.
//  - Write dis_data<=channel[sel] every cycle, using the registered sel. Latency: a page change
//    on edge n shows in sel after edge n and in dis_data after edge n+1. With static content,
//    dis_data follows a content change one cycle later.
//  - sel_changed<=1 on the edge after any edge where sel took a different value; 0 otherwise.
//    Loading the current value gives no pulse. It aligns with the first cycle of new dis_data.
//  - Reset mid-operation: all state returns to reset values at once, with no glitch pulse on
//    release.
//  - No combinational path from inputs to outputs.
// TESTING
//  T1 reset: drive reset_n=0 mid-run -> sel=0, dis_data=0, sel_changed=0 immediately;
//     1 clk after release, dis_data=ch0.
//  T2 wrap: N_CH=12, sel=11, next pulse -> sel=0; then prev pulse -> sel=11;
//     sel_changed pulses once each; dis_data=ch0 then ch11, each 1 cycle after sel.
//  T3 load range: load sel_in=5 -> sel=5, dis_data=ch5 two edges after load;
//     load sel_in=13 -> sel stays 5, no sel_changed.
//  T4 priority: load(sel_in=2)+next in same cycle -> sel=2;
//     next+prev together -> sel unchanged, no pulse.
//  T5 auto-rotate: auto_en=1, DWELL=4, tick every 10 clk -> sel advances 0->1 on 4th tick;
//     a next pulse between ticks restarts the count (4 more ticks to the next step);
//     auto_en=0 -> never advances.
//  T6 content tracking: hold sel=3, change ch3 value -> dis_data updates exactly 1 cycle later;
//     ch4 changes have no effect.

Source files
------------

// File: rtl/display_7s_page_sel.sv
// Registered page selector for the 7-segment path: picks one of N_CH content words by a page index
// moved by next/prev/load pulses or an auto-rotate dwell timer. Latency: sel 1 clk, dis_data 2 clk.
module display_7s_page_sel #(
  parameter int N_CH  = 12,
  parameter int DW    = 80,
  parameter int DWELL = 4,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_CH*DW-1:0] dis_content,
  input  logic             next,
  input  logic             prev,
  input  logic             load,
  input  logic [SW-1:0]    sel_in,
  input  logic             auto_en,
  input  logic             tick,
  output logic [DW-1:0]    dis_data,
  output logic [SW-1:0]    sel,
  output logic             sel_changed
);

  localparam logic [SW:0]   LP_NCH      = (SW+1)'(N_CH);
  localparam logic [SW-1:0] LP_LAST     = SW'(N_CH - 1);
  localparam logic [7:0]    LP_DWELL_M1 = 8'(DWELL - 1);

  logic [SW-1:0] r_sel;
  logic [7:0]    r_dwell;
  logic          r_chg_pend;
  logic          r_sel_changed;
  logic [DW-1:0] r_dis_data;

  logic          w_manual;
  logic          w_load_ok;
  logic          w_expire;
  logic [SW-1:0] w_sel_inc;
  logic [SW-1:0] w_sel_dec;
  logic [SW-1:0] w_sel_nxt;

  assign w_manual  = load | next | prev;
  assign w_load_ok = ({1'b0, sel_in} < LP_NCH);
  assign w_expire  = auto_en & tick & (r_dwell == LP_DWELL_M1);
  assign w_sel_inc = (r_sel == LP_LAST) ? '0 : r_sel + 1'b1;
  assign w_sel_dec = (r_sel == '0) ? LP_LAST : r_sel - 1'b1;

  // Manual actions outrank a dwell expiry; out-of-range loads and next+prev both hold the page.
  always_comb begin
    w_sel_nxt = r_sel;
    if (load) begin
      if (w_load_ok) w_sel_nxt = sel_in;
    end else if (next && prev) begin
      w_sel_nxt = r_sel;
    end else if (next) begin
      w_sel_nxt = w_sel_inc;
    end else if (prev) begin
      w_sel_nxt = w_sel_dec;
    end else if (w_expire) begin
      w_sel_nxt = w_sel_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel         <= '0;
      r_dwell       <= '0;
      r_chg_pend    <= 1'b0;
      r_sel_changed <= 1'b0;
      r_dis_data    <= '0;
    end else begin
      r_sel <= w_sel_nxt;
      if (!auto_en || w_manual || w_expire) r_dwell <= '0;
      else if (tick)                        r_dwell <= r_dwell + 8'd1;
      // Delayed one extra stage so the pulse lines up with the first cycle of new dis_data.
      r_chg_pend    <= (w_sel_nxt != r_sel);
      r_sel_changed <= r_chg_pend;
      r_dis_data    <= dis_content[r_sel*DW +: DW];
    end
  end

  assign sel         = r_sel;
  assign sel_changed = r_sel_changed;
  assign dis_data    = r_dis_data;

endmodule

// File: tb/tb_display_7s_page_sel.sv
// Directed self-checking bench for display_7s_page_sel (N_CH=12, DW=80, DWELL=4).
module tb_display_7s_page_sel;
  localparam int N_CH = 12;
  localparam int DW   = 80;
  localparam int SW   = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N_CH*DW-1:0]   dis_content;
  logic                 next, prev, load, auto_en, tick;
  logic [SW-1:0]        sel_in;
  logic [DW-1:0]        dis_data;
  logic [SW-1:0]        sel;
  logic                 sel_changed;

  int checks = 0;
  int errors = 0;

  display_7s_page_sel #(.N_CH(N_CH), .DW(DW), .DWELL(4)) dut (
    .clk(clk), .reset_n(reset_n), .dis_content(dis_content),
    .next(next), .prev(prev), .load(load), .sel_in(sel_in),
    .auto_en(auto_en), .tick(tick),
    .dis_data(dis_data), .sel(sel), .sel_changed(sel_changed)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] chv(input int k, input logic [7:0] salt);
    logic [7:0] b;
    b = 8'(k * 17 + 1) ^ salt;
    return {10{b}};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [SW-1:0] v);
    @(negedge clk); load = 1'b1; sel_in = v;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic do_next();
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
  endtask

  task automatic do_prev();
    @(negedge clk); prev = 1'b1;
    @(negedge clk); prev = 1'b0;
  endtask

  task automatic do_tick();
    repeat (9) @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (sel !== 4'd0)       begin errors++; $display("FAIL rst_sel got %0d exp 0", sel); end
    checks++; if (dis_data !== '0)    begin errors++; $display("FAIL rst_data got %h exp 0", dis_data); end
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL rst_chg got %b exp 0", sel_changed); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (dis_data !== chv(0, 8'h00)) begin errors++; $display("FAIL rel_data got %h exp %h", dis_data, chv(0, 8'h00)); end
    // Mid-run reset while a change pulse is pending
    do_load(4'd3);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (sel !== 4'd0)       begin errors++; $display("FAIL mid_rst_sel got %0d exp 0", sel); end
    checks++; if (dis_data !== '0)    begin errors++; $display("FAIL mid_rst_data got %h exp 0", dis_data); end
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL mid_rst_chg got %b exp 0", sel_changed); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL rel_glitch got %b exp 0", sel_changed); end
    checks++; if (dis_data !== chv(0, 8'h00)) begin errors++; $display("FAIL rel2_data got %h exp %h", dis_data, chv(0, 8'h00)); end
  endtask

  task automatic test_wrap();
    do_load(4'd11);
    cyc(3);
    do_next();
    checks++; if (sel !== 4'd0)         begin errors++; $display("FAIL wrap_next_sel got %0d exp 0", sel); end
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL wrap_next_early got %b exp 0", sel_changed); end
    checks++; if (dis_data !== chv(11, 8'h00)) begin errors++; $display("FAIL wrap_next_old got %h exp %h", dis_data, chv(11, 8'h00)); end
    @(negedge clk);
    checks++; if (dis_data !== chv(0, 8'h00)) begin errors++; $display("FAIL wrap_next_data got %h exp %h", dis_data, chv(0, 8'h00)); end
    checks++; if (sel_changed !== 1'b1) begin errors++; $display("FAIL wrap_next_pulse got %b exp 1", sel_changed); end
    @(negedge clk);
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL wrap_next_once got %b exp 0", sel_changed); end
    do_prev();
    checks++; if (sel !== 4'd11)        begin errors++; $display("FAIL wrap_prev_sel got %0d exp 11", sel); end
    @(negedge clk);
    checks++; if (dis_data !== chv(11, 8'h00)) begin errors++; $display("FAIL wrap_prev_data got %h exp %h", dis_data, chv(11, 8'h00)); end
    checks++; if (sel_changed !== 1'b1) begin errors++; $display("FAIL wrap_prev_pulse got %b exp 1", sel_changed); end
    @(negedge clk);
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL wrap_prev_once got %b exp 0", sel_changed); end
  endtask

  task automatic test_load();
    do_load(4'd5);
    checks++; if (sel !== 4'd5) begin errors++; $display("FAIL load5_sel got %0d exp 5", sel); end
    @(negedge clk);
    checks++; if (dis_data !== chv(5, 8'h00)) begin errors++; $display("FAIL load5_data got %h exp %h", dis_data, chv(5, 8'h00)); end
    do_load(4'd13);
    checks++; if (sel !== 4'd5) begin errors++; $display("FAIL load13_sel got %0d exp 5", sel); end
    @(negedge clk);
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL load13_pulse got %b exp 0", sel_changed); end
    do_load(4'd5);
    @(negedge clk);
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL loadsame_pulse got %b exp 0", sel_changed); end
  endtask

  task automatic test_priority();
    @(negedge clk); load = 1'b1; sel_in = 4'd2; next = 1'b1;
    @(negedge clk); load = 1'b0; next = 1'b0;
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL prio_load_sel got %0d exp 2", sel); end
    cyc(2);
    @(negedge clk); next = 1'b1; prev = 1'b1;
    @(negedge clk); next = 1'b0; prev = 1'b0;
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL prio_cancel_sel got %0d exp 2", sel); end
    @(negedge clk);
    checks++; if (sel_changed !== 1'b0) begin errors++; $display("FAIL prio_cancel_pulse got %b exp 0", sel_changed); end
  endtask

  task automatic test_auto();
    auto_en = 1'b0;
    do_load(4'd0);
    auto_en = 1'b1;
    repeat (3) do_tick();
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL auto_3tick got %0d exp 0", sel); end
    do_tick();
    checks++; if (sel !== 4'd1) begin errors++; $display("FAIL auto_4tick got %0d exp 1", sel); end
    repeat (2) do_tick();
    do_next();
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL auto_next got %0d exp 2", sel); end
    repeat (3) do_tick();
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL auto_restart3 got %0d exp 2", sel); end
    do_tick();
    checks++; if (sel !== 4'd3) begin errors++; $display("FAIL auto_restart4 got %0d exp 3", sel); end
    // prev coincides with the dwell expiry: only the manual step is taken
    repeat (3) do_tick();
    repeat (9) @(negedge clk);
    tick = 1'b1; prev = 1'b1;
    @(negedge clk); tick = 1'b0; prev = 1'b0;
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL auto_manual_wins got %0d exp 2", sel); end
    auto_en = 1'b0;
    repeat (6) do_tick();
    checks++; if (sel !== 4'd2) begin errors++; $display("FAIL auto_off got %0d exp 2", sel); end
  endtask

  task automatic test_content();
    do_load(4'd3);
    cyc(2);
    checks++; if (dis_data !== chv(3, 8'h00)) begin errors++; $display("FAIL cont_base got %h exp %h", dis_data, chv(3, 8'h00)); end
    dis_content[3*DW +: DW] = chv(3, 8'hA5);
    #1;
    checks++; if (dis_data !== chv(3, 8'h00)) begin errors++; $display("FAIL cont_early got %h exp %h", dis_data, chv(3, 8'h00)); end
    @(negedge clk);
    checks++; if (dis_data !== chv(3, 8'hA5)) begin errors++; $display("FAIL cont_follow got %h exp %h", dis_data, chv(3, 8'hA5)); end
    dis_content[4*DW +: DW] = chv(4, 8'h5A);
    cyc(2);
    checks++; if (dis_data !== chv(3, 8'hA5)) begin errors++; $display("FAIL cont_other got %h exp %h", dis_data, chv(3, 8'hA5)); end
  endtask

  initial begin
    reset_n = 1'b0;
    next = 1'b0; prev = 1'b0; load = 1'b0; auto_en = 1'b0; tick = 1'b0;
    sel_in = '0;
    for (int k = 0; k < N_CH; k++) dis_content[k*DW +: DW] = chv(k, 8'h00);
    #12;
    test_reset();
    test_wrap();
    test_load();
    test_priority();
    test_auto();
    test_content();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
